// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe
//   Two-stage normalise-and-round unit. Stage 1 finds the leading one of an
//   unnormalised magnitude, left-aligns it to the hidden-bit position (or
//   right-shifts into the denormal range) and reduces the tail to guard,
//   round and sticky bits. Stage 2 applies the rounding mode, handles mantissa
//   carry-out, overflow saturation, denormal/zero packing and raises flags.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   in_valid_i/in_ready_o input handshake
//   mant_i               unnormalised magnitude, binary point below the top two bits
//   exp_i                signed biased exponent of mant_i
//   sign_i               sign of the operand
//   rm_i                 rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM)
//   out_valid_o/out_ready_i output handshake
//   res_o                packed {sign, exponent, fraction}
//   flags_o              {overflow, underflow, inexact}
module fp_norm_round_pipe #(
  parameter int C_EXP          = 5,
  parameter int C_MANT         = 10,
  parameter int C_MANT_PRENORM = 22,
  parameter int C_EXP_PRENORM  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [C_MANT_PRENORM-1:0] mant_i,
  input  logic [C_EXP_PRENORM-1:0]  exp_i,
  input  logic                      sign_i,
  input  logic [2:0]                rm_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [C_EXP+C_MANT:0]     res_o,
  output logic [2:0]                flags_o
);

  localparam int C_BIAS = 2**(C_EXP-1) - 1;
  localparam int EW     = C_EXP_PRENORM + 2;
  localparam int PW     = $clog2(C_MANT_PRENORM);
  localparam int SHMAX  = C_MANT + 3;
  localparam int SW     = $clog2(SHMAX + 1);
  localparam int XW     = C_MANT_PRENORM + SHMAX;
  localparam logic signed [EW-1:0] EXP_INF = EW'(2*C_BIAS + 1);

  // ---------------- stage 1: normalise ----------------
  logic [PW-1:0]             lead_pos;
  logic [C_MANT_PRENORM-1:0] norm;
  logic signed [EW-1:0]      e_calc;
  logic [EW-1:0]             dn_shift_raw;
  logic [SW-1:0]             dn_shift;
  logic                      den_d;
  logic [XW-1:0]             ext;
  logic [XW-1:0]             aligned;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < C_MANT_PRENORM; i++) begin
      if (mant_i[i]) lead_pos = PW'(i);
    end
  end

  always_comb begin
    norm   = mant_i << (PW'(C_MANT_PRENORM - 1) - lead_pos);
    e_calc = {{2{exp_i[C_EXP_PRENORM-1]}}, exp_i} + EW'(lead_pos) - EW'(C_MANT_PRENORM - 2);
    den_d  = e_calc[EW-1] | (e_calc == '0);
    // only meaningful when den_d, where 1-e is a positive distance
    dn_shift_raw = EW'(1) - e_calc;
    if (!den_d)
      dn_shift = '0;
    else if (dn_shift_raw > EW'(SHMAX))
      dn_shift = SW'(SHMAX);
    else
      dn_shift = dn_shift_raw[SW-1:0];
    // zero padding below the mantissa holds every shifted-out bit for sticky
    ext     = {norm, {SHMAX{1'b0}}};
    aligned = ext >> dn_shift;
  end

  logic                  s1_valid;
  logic [C_MANT:0]       s1_m;
  logic                  s1_g, s1_r, s1_s;
  logic signed [EW-1:0]  s1_e;
  logic                  s1_sign, s1_den, s1_zero;
  logic [2:0]            s1_rm;

  // ---------------- stage 2: round and pack ----------------
  logic                  any_lost, up, inf_sel, ovf;
  logic [C_MANT+1:0]     sum;
  logic [C_MANT-1:0]     frac;
  logic signed [EW-1:0]  e_fin;
  logic [C_EXP+C_MANT:0] res_d;
  logic [2:0]            flags_d;

  always_comb begin
    any_lost = s1_g | s1_r | s1_s;
    case (s1_rm)
      3'b001:  up = 1'b0;
      3'b010:  up = any_lost & s1_sign;
      3'b011:  up = any_lost & ~s1_sign;
      3'b100:  up = s1_g;
      default: up = s1_g & (s1_r | s1_s | s1_m[0]);
    endcase
    sum = {1'b0, s1_m} + {{(C_MANT+1){1'b0}}, up};
    if (s1_den) begin
      // rounding into the hidden bit turns the denormal into the smallest normal
      frac  = sum[C_MANT-1:0];
      e_fin = sum[C_MANT] ? EW'(1) : '0;
    end else if (sum[C_MANT+1]) begin
      frac  = sum[C_MANT:1];
      e_fin = s1_e + EW'(1);
    end else begin
      frac  = sum[C_MANT-1:0];
      e_fin = s1_e;
    end
    ovf = ~s1_den & (e_fin >= EXP_INF);
    case (s1_rm)
      3'b001:  inf_sel = 1'b0;
      3'b010:  inf_sel = s1_sign;
      3'b011:  inf_sel = ~s1_sign;
      default: inf_sel = 1'b1;
    endcase
    res_d   = {s1_sign, e_fin[C_EXP-1:0], frac};
    flags_d = {ovf, s1_den & any_lost, any_lost | ovf};
    if (s1_zero) begin
      res_d   = {s1_sign, {(C_EXP+C_MANT){1'b0}}};
      flags_d = 3'b000;
    end else if (ovf) begin
      if (inf_sel)
        res_d = {s1_sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
      else
        res_d = {s1_sign, {(C_EXP-1){1'b1}}, 1'b0, {C_MANT{1'b1}}};
    end
  end

  // ---------------- handshake and registers ----------------
  logic s2_valid, s1_load, s2_load;

  assign s2_load    = ~s2_valid | out_ready_i;
  assign s1_load    = ~s1_valid | s2_load;
  assign in_ready_o = s1_load;
  assign out_valid_o = s2_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_m     <= '0;
      s1_g     <= 1'b0;
      s1_r     <= 1'b0;
      s1_s     <= 1'b0;
      s1_e     <= '0;
      s1_sign  <= 1'b0;
      s1_den   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_rm    <= 3'b000;
      s2_valid <= 1'b0;
      res_o    <= '0;
      flags_o  <= 3'b000;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid_i;
        if (in_valid_i) begin
          s1_m    <= aligned[XW-1 -: C_MANT+1];
          s1_g    <= aligned[XW-C_MANT-2];
          s1_r    <= aligned[XW-C_MANT-3];
          s1_s    <= |aligned[XW-C_MANT-4:0];
          s1_e    <= e_calc;
          s1_sign <= sign_i;
          s1_den  <= den_d;
          s1_zero <= (mant_i == '0);
          s1_rm   <= rm_i;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          res_o   <= res_d;
          flags_o <= flags_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
module tb_fp_norm_round_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [21:0] mant_i;
  logic [7:0]  exp_i;
  logic        sign_i;
  logic [2:0]  rm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] res_o;
  logic [2:0]  flags_o;

  fp_norm_round_pipe dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .mant_i      (mant_i),
    .exp_i       (exp_i),
    .sign_i      (sign_i),
    .rm_i        (rm_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .res_o       (res_o),
    .flags_o     (flags_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int cyc      = 0;
  logic [18:0] exp_q[$];
  logic [15:0] last_res;
  logic [2:0]  last_flags;
  logic        stalled = 1'b0;
  logic [15:0] held_res;
  logic [2:0]  held_flags;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: value = m * 2^(e-35); quantise to the fp16 ulp grid and round
  // using the exact remainder against half an ulp. Returns {flags, res}.
  function automatic logic [18:0] ref_round(input logic [21:0] m, input logic [7:0] e8,
                                            input logic s, input logic [2:0] r);
    int ex, msb, big_e, k;
    longint q, rem, half;
    logic up, ovf, tiny, inf_sel;
    logic [15:0] res;
    if (m == 0) return {3'b000, s, 15'd0};
    ex  = int'($signed(e8));
    msb = 0;
    for (int i = 0; i < 22; i++) if (m[i]) msb = i;
    big_e = msb + ex - 20;
    tiny  = (big_e < 1);
    k = ex - 10 - ((big_e > 1) ? big_e : 1);
    if (k >= 0) begin
      q = longint'(m) << k; rem = 0; half = 1;
    end else if (k < -40) begin
      q = 0; rem = 1; half = 2;
    end else begin
      q = longint'(m) >> (-k);
      rem = longint'(m) - (q << (-k));
      half = longint'(1) << (-k - 1);
    end
    case (r)
      3'b001:  up = 1'b0;
      3'b010:  up = (rem != 0) && s;
      3'b011:  up = (rem != 0) && !s;
      3'b100:  up = (rem >= half);
      default: up = (rem > half) || ((rem == half) && q[0]);
    endcase
    if (up) q = q + 1;
    if (q == 2048) begin q = 1024; big_e = big_e + 1; end
    if (tiny) big_e = (q >= 1024) ? 1 : 0;
    ovf = (big_e >= 31);
    case (r)
      3'b001:  inf_sel = 1'b0;
      3'b010:  inf_sel = s;
      3'b011:  inf_sel = !s;
      default: inf_sel = 1'b1;
    endcase
    if (ovf) res = inf_sel ? {s, 15'h7C00} : {s, 15'h7BFF};
    else     res = {s, big_e[4:0], q[9:0]};
    return {ovf, tiny && (rem != 0), (rem != 0) || ovf, res};
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Compare process: model pushed on every input handshake, popped on every
  // output handshake; a stalled output must hold its value.
  always @(negedge clk_i) begin
    logic [18:0] e;
    if (rst_i) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_res_stable", 32'(res_o), 32'(held_res));
        chk("stall_flags_stable", 32'(flags_o), 32'(held_flags));
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 32'(out_valid_o), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_res", 32'(res_o), 32'(e[15:0]));
          chk("out_flags", 32'(flags_o), 32'(e[18:16]));
          last_res   = res_o;
          last_flags = flags_o;
          n_out++;
        end
      end
      stalled    = out_valid_o && !out_ready_i;
      held_res   = res_o;
      held_flags = flags_o;
      if (in_valid_i && in_ready_o) exp_q.push_back(ref_round(mant_i, exp_i, sign_i, rm_i));
    end
  end

  typedef struct {
    logic [21:0] m;
    logic [7:0]  e;
    logic        s;
    logic [2:0]  r;
    logic [15:0] res;
    logic [2:0]  fl;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [21:0] m, input logic [7:0] e, input logic s,
                              input logic [2:0] r, input logic [15:0] res, input logic [2:0] fl);
    vec_t v;
    v.m = m; v.e = e; v.s = s; v.r = r; v.res = res; v.fl = fl;
    return v;
  endfunction

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input vec_t v);
    int guard = 0;
    mant_i = v.m; exp_i = v.e; sign_i = v.s; rm_i = v.r; in_valid_i = 1'b1;
    @(negedge clk_i);
    while (!in_ready_o && guard < 200) begin guard++; @(negedge clk_i); end
    if (!in_ready_o) chk("send_timeout_in_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk_i);
    while ((exp_q.size() != 0 || out_valid_o) && guard < 200) begin guard++; @(negedge clk_i); end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp_start;
    logic snd_done;
    logic [31:0] tmp;
    vec_t v;
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    mant_i = '0; exp_i = '0; sign_i = 1'b0; rm_i = 3'b000;

    vecs.push_back(mk(22'h100000, 8'd15,  1'b0, 3'd0, 16'h3C00, 3'b000));
    vecs.push_back(mk(22'h3FFFFF, 8'd15,  1'b0, 3'd0, 16'h4400, 3'b001));
    vecs.push_back(mk(22'h3FFFFF, 8'd15,  1'b0, 3'd1, 16'h43FF, 3'b001));
    vecs.push_back(mk(22'h3FFFFF, 8'd15,  1'b1, 3'd2, 16'hC400, 3'b001));
    vecs.push_back(mk(22'h100000, 8'd31,  1'b0, 3'd0, 16'h7C00, 3'b101));
    vecs.push_back(mk(22'h100000, 8'd31,  1'b0, 3'd1, 16'h7BFF, 3'b101));
    vecs.push_back(mk(22'h100000, 8'd31,  1'b1, 3'd3, 16'hFBFF, 3'b101));
    vecs.push_back(mk(22'h100000, 8'hFB,  1'b0, 3'd0, 16'h0010, 3'b000));
    vecs.push_back(mk(22'h100000, 8'hF6,  1'b0, 3'd0, 16'h0000, 3'b011));
    vecs.push_back(mk(22'h100000, 8'hF6,  1'b0, 3'd3, 16'h0001, 3'b011));
    vecs.push_back(mk(22'h000000, 8'd0,   1'b1, 3'd0, 16'h8000, 3'b000));
    vecs.push_back(mk(22'h100200, 8'd15,  1'b0, 3'd0, 16'h3C00, 3'b001));
    vecs.push_back(mk(22'h100200, 8'd15,  1'b0, 3'd4, 16'h3C01, 3'b001));
    vecs.push_back(mk(22'h100600, 8'd15,  1'b0, 3'd0, 16'h3C02, 3'b001));
    vecs.push_back(mk(22'h100200, 8'd15,  1'b0, 3'd5, 16'h3C00, 3'b001));
    vecs.push_back(mk(22'h3FFFFF, 8'hFF,  1'b0, 3'd0, 16'h0400, 3'b011));

    foreach (vecs[i])
      chk($sformatf("model_vec%0d", i),
          32'(ref_round(vecs[i].m, vecs[i].e, vecs[i].s, vecs[i].r)),
          32'({vecs[i].fl, vecs[i].res}));

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_out_valid", 32'(out_valid_o), 32'd0);
    chk("reset_res", 32'(res_o), 32'd0);
    chk("reset_flags", 32'(flags_o), 32'd0);
    chk("reset_in_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk_i); #1;

    // latency: handshake cycle c, out_valid visible in cycle c+2
    send(vecs[0]);
    @(negedge clk_i); chk("latency_not_early", 32'(out_valid_o), 32'd0);
    @(negedge clk_i); chk("latency_visible", 32'(out_valid_o), 32'd1);
    @(posedge clk_i); #1;
    drain();

    foreach (vecs[i]) begin
      send(vecs[i]);
      drain();
      chk($sformatf("vec%0d_res", i), 32'(last_res), 32'(vecs[i].res));
      chk($sformatf("vec%0d_flags", i), 32'(last_flags), 32'(vecs[i].fl));
    end

    // full throughput
    bp_start = cyc;
    for (int j = 1; j <= 4; j++) send(vecs[j]);
    chk("throughput_cycles", 32'(cyc - bp_start), 32'd4);
    drain();

    // backpressure: capacity two, stalled output held, all four beats emerge
    out_ready_i = 1'b0;
    bp_start = n_out;
    fork
      begin
        send(vecs[1]); send(vecs[2]); send(vecs[8]); send(vecs[9]);
      end
      begin
        repeat (3) @(negedge clk_i);
        chk("bp_in_ready_low", 32'(in_ready_o), 32'd0);
        chk("bp_out_valid", 32'(out_valid_o), 32'd1);
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
      end
    join
    drain();
    chk("bp_beats_out", 32'(n_out - bp_start), 32'd4);

    // reset with two beats in flight and a beat offered during reset
    out_ready_i = 1'b0;
    send(vecs[4]); send(vecs[5]);
    rst_i = 1'b1; in_valid_i = 1'b1; mant_i = 22'h2AAAAA; exp_i = 8'd15; sign_i = 1'b0; rm_i = 3'd0;
    @(posedge clk_i); #1;
    rst_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_mid_res", 32'(res_o), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready_o), 32'd1);
    out_ready_i = 1'b1;
    repeat (4) begin @(negedge clk_i); chk("rst_no_stale_out", 32'(out_valid_o), 32'd0); end
    @(posedge clk_i); #1;
    send(vecs[2]);
    @(negedge clk_i); chk("rst_next_not_early", 32'(out_valid_o), 32'd0);
    @(negedge clk_i); chk("rst_next_visible", 32'(out_valid_o), 32'd1);
    @(posedge clk_i); #1;
    drain();
    chk("rst_next_res", 32'(last_res), 32'h43FF);

    // exponent/mantissa/mode sweep with a periodic ready pattern
    snd_done = 1'b0;
    fork
      begin
        for (int j = 0; j < 48; j++) begin
          tmp = 32'(j) * 32'd2654435761;
          v = mk(tmp[28:7], 8'(j * 3 - 40), tmp[3], 3'(j % 8), 16'h0, 3'b0);
          send(v);
        end
        snd_done = 1'b1;
      end
      begin
        int g = 0;
        while (!snd_done && g < 1000) begin
          @(posedge clk_i); #1;
          out_ready_i = (g % 3 != 2);
          g++;
        end
        out_ready_i = 1'b1;
      end
    join
    out_ready_i = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
